// File: rtl/dcache_sram_array_pkg.sv
// dcache_sram_array_pkg
//   Shared geometry and helpers for the L1 D-cache storage array.
//   - Size constants: tag/set widths, block size, associativity.
//   - Address field slicing: blockAddr = {tag, set}, with set in the LSBs.
//   - Byte-masked line merge used by CPU write hits.
//   Replacement selection: define DCACHE_PLRU_EN for tree pseudo-LRU;
//   leave it undefined for true LRU with age counters.
package dcache_sram_array_pkg;

  localparam int DTAG_SIZE        = 3;
  localparam int DSET_INDEX_SIZE  = 1;
  localparam int DBLOCK_SIZE      = 8;
  localparam int DBLOCK_SIZE_BITS = DBLOCK_SIZE * 8;
  localparam int DWAYS            = 4;
  localparam int DSETS            = 1 << DSET_INDEX_SIZE;
  localparam int WAY_W            = $clog2(DWAYS);
  localparam int ADDR_W           = DTAG_SIZE + DSET_INDEX_SIZE;

  typedef logic [DTAG_SIZE-1:0]        tag_t;
  typedef logic [DSET_INDEX_SIZE-1:0]  set_t;
  typedef logic [WAY_W-1:0]            way_t;
  typedef logic [ADDR_W-1:0]           addr_t;
  typedef logic [DBLOCK_SIZE-1:0]      bmask_t;
  typedef logic [DBLOCK_SIZE_BITS-1:0] line_t;

  function automatic set_t addr_set(addr_t a);
    return a[DSET_INDEX_SIZE-1:0];
  endfunction

  function automatic tag_t addr_tag(addr_t a);
    return a[ADDR_W-1:DSET_INDEX_SIZE];
  endfunction

  // Bytes with mask=1 come from nxt, the rest keep cur.
  function automatic line_t merge_bytes(line_t cur, line_t nxt, bmask_t mask);
    line_t r;
    r = cur;
    for (int i = 0; i < DBLOCK_SIZE; i++) begin
      if (mask[i]) r[i*8 +: 8] = nxt[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_sram_array_if.sv
// dcache_sram_array_if
//   CPU/refill access bus between the cache controller (master) and the
//   storage array (slave).
//   master drives: ren, wen, memWen, bytesAccess, blockAddr, dataIn
//   slave drives : hit, dirtyBit, dataOut (combinational lookup results)
interface dcache_sram_array_if;
  import dcache_sram_array_pkg::*;

  logic   ren;
  logic   wen;
  logic   memWen;
  bmask_t bytesAccess;
  addr_t  blockAddr;
  line_t  dataIn;
  logic   hit;
  logic   dirtyBit;
  line_t  dataOut;

  modport master (
    output ren, wen, memWen, bytesAccess, blockAddr, dataIn,
    input  hit, dirtyBit, dataOut
  );

  modport slave (
    input  ren, wen, memWen, bytesAccess, blockAddr, dataIn,
    output hit, dirtyBit, dataOut
  );
endinterface

// File: rtl/dcache_repl_policy.sv
// dcache_repl_policy
//   Per-set replacement state for the D-cache array.
//   Ports:
//     clk, rst         clock; synchronous active-low reset of all state
//     touch_en         mark touch_way of touch_set most-recently-used
//     touch_set/way    set and way being touched this cycle
//     query_set        set whose replacement victim is requested
//     victim           way to evict when every way of query_set is valid
//   DCACHE_PLRU_EN defined: binary-tree pseudo-LRU, DWAYS-1 bits per set.
//   Undefined: true LRU with one WAY_W-bit age per way (0 = MRU).
module dcache_repl_policy
  import dcache_sram_array_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic touch_en,
  input  set_t touch_set,
  input  way_t touch_way,
  input  set_t query_set,
  output way_t victim
);

`ifdef DCACHE_PLRU_EN
  localparam int NODES = DWAYS - 1;

  // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right).
  // A node bit of 0 points the victim search left, 1 points it right.
  logic [NODES-1:0] tree_q [DSETS];

  function automatic logic [NODES-1:0] plru_touch(logic [NODES-1:0] t, way_t w);
    logic [NODES-1:0] r;
    way_t             wc;
    logic             b;
    int               node;
    r    = t;
    wc   = w;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b  = wc[WAY_W-1];
      wc = wc << 1;
      // Point this node away from the half that was just used.
      r[node[WAY_W-1:0]] = ~b;
      node = 2 * node + 1 + int'(b);
    end
    return r;
  endfunction

  function automatic way_t plru_victim(logic [NODES-1:0] t);
    way_t v;
    logic b;
    int   node;
    v    = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b    = t[node[WAY_W-1:0]];
      v    = way_t'((int'(v) << 1) | int'(b));
      node = 2 * node + 1 + int'(b);
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < DSETS; s++) tree_q[s] <= '0;
    end else if (touch_en) begin
      tree_q[touch_set] <= plru_touch(tree_q[touch_set], touch_way);
    end
  end

  assign victim = plru_victim(tree_q[query_set]);

`else
  // Ages within a set always form a permutation of 0..DWAYS-1, so the
  // oldest way is unique. Reset seeds that permutation with the way index.
  way_t age_q [DSETS][DWAYS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < DSETS; s++) begin
        for (int w = 0; w < DWAYS; w++) age_q[s][w] <= way_t'(w);
      end
    end else if (touch_en) begin
      for (int w = 0; w < DWAYS; w++) begin
        if (way_t'(w) == touch_way) begin
          age_q[touch_set][w] <= '0;
        end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
          age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    way_t best;
    best = '0;
    for (int w = 1; w < DWAYS; w++) begin
      if (age_q[query_set][w] > age_q[query_set][best]) best = way_t'(w);
    end
    victim = best;
  end
`endif

endmodule

// File: rtl/dcache_sram_array.sv
// dcache_sram_array
//   Data/tag/state storage of the L1 D-cache: 4-way set-associative,
//   write-back, 8-byte blocks, 2 sets.
//   Ports:
//     clk   clock, all state updates on posedge
//     rst   synchronous active-low reset: clears valid, dirty and
//           replacement state (tags and data are kept); forces outputs to 0
//     bus   dcache_sram_array_if.slave
//           in : ren, wen, memWen, bytesAccess, blockAddr, dataIn
//           out: hit, dirtyBit, dataOut (zero-latency lookup of blockAddr)
//   Update priority: memWen > wen > ren. Misses on ren/wen change nothing.
//   Build option: DCACHE_PLRU_EN selects tree pseudo-LRU in
//   dcache_repl_policy; default is true LRU.
module dcache_sram_array
  import dcache_sram_array_pkg::*;
(
  input  logic clk,
  input  logic rst,
  dcache_sram_array_if.slave bus
);

  logic [DWAYS-1:0] valid_q [DSETS];
  logic [DWAYS-1:0] dirty_q [DSETS];
  tag_t             tag_q   [DSETS][DWAYS];
  line_t            data_q  [DSETS][DWAYS];

  set_t             set;
  tag_t             tag;
  logic [DWAYS-1:0] match;
  logic             any_match;
  way_t             match_way;
  logic             has_free;
  way_t             free_way;
  way_t             repl_way;
  way_t             victim_way;
  way_t             sel_way;
  way_t             fill_way;
  logic             hit_int;
  logic             do_fill;
  logic             do_write;
  logic             do_read;
  logic             touch_en;
  way_t             touch_way;

  assign set = addr_set(bus.blockAddr);
  assign tag = addr_tag(bus.blockAddr);

  always_comb begin
    match     = '0;
    match_way = '0;
    has_free  = 1'b0;
    free_way  = '0;
    for (int w = 0; w < DWAYS; w++) begin
      match[w] = valid_q[set][w] && (tag_q[set][w] == tag);
      if (match[w]) match_way = way_t'(w);
    end
    // Descending scan so the lowest-indexed invalid way wins.
    for (int w = DWAYS - 1; w >= 0; w--) begin
      if (!valid_q[set][w]) begin
        has_free = 1'b1;
        free_way = way_t'(w);
      end
    end
  end

  assign any_match  = |match;
  assign victim_way = has_free ? free_way : repl_way;
  assign hit_int    = (bus.ren | bus.wen) & any_match;
  assign sel_way    = hit_int ? match_way : victim_way;
  // A refill of a tag already present reuses its way to avoid duplicates.
  assign fill_way   = any_match ? match_way : victim_way;

  assign bus.hit      = rst & hit_int;
  assign bus.dirtyBit = rst & dirty_q[set][sel_way];
  assign bus.dataOut  = rst ? data_q[set][sel_way] : '0;

  assign do_fill   = rst & bus.memWen;
  assign do_write  = rst & ~bus.memWen & bus.wen & any_match;
  assign do_read   = rst & ~bus.memWen & ~bus.wen & bus.ren & any_match;
  assign touch_en  = do_fill | do_write | do_read;
  assign touch_way = do_fill ? fill_way : match_way;

  dcache_repl_policy u_repl (
    .clk       (clk),
    .rst       (rst),
    .touch_en  (touch_en),
    .touch_set (set),
    .touch_way (touch_way),
    .query_set (set),
    .victim    (repl_way)
  );

  // Line state: valid/dirty are the only bits reset clears.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < DSETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if (do_fill) begin
      valid_q[set][fill_way] <= 1'b1;
      dirty_q[set][fill_way] <= 1'b0;
    end else if (do_write) begin
      dirty_q[set][match_way] <= 1'b1;
    end
  end

  // Tag/data storage: never reset, written only on refill or write hit.
  always_ff @(posedge clk) begin
    if (do_fill) begin
      tag_q[set][fill_way]  <= tag;
      data_q[set][fill_way] <= bus.dataIn;
    end else if (do_write) begin
      data_q[set][match_way] <= merge_bytes(data_q[set][match_way], bus.dataIn,
                                            bus.bytesAccess);
    end
  end

endmodule

// File: tb/tb_dcache_sram_array.sv
module tb_dcache_sram_array;
  import dcache_sram_array_pkg::*;

  logic clk;
  logic rst;
  dcache_sram_array_if bus();

  dcache_sram_array dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: what each way holds, plus a recency record per way.
  bit      m_valid [DSETS][DWAYS];
  bit      m_dirty [DSETS][DWAYS];
  bit      m_known [DSETS][DWAYS];
  tag_t    m_tag   [DSETS][DWAYS];
  line_t   m_data  [DSETS][DWAYS];
  longint  m_last  [DSETS][DWAYS];
  bit      m_tree  [DSETS][DWAYS];
  longint  stamp_now;

  logic    e_hit;
  logic    e_dirty;
  line_t   e_data;
  bit      e_data_known;
  int      e_match;
  int      e_victim;

  line_t   saved [8];

  function automatic addr_t mk_addr(int t, int s);
    return addr_t'((t << DSET_INDEX_SIZE) | s);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < DSETS; s++) begin
      for (int w = 0; w < DWAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_last[s][w]  = -longint'(w);
        m_tree[s][w]  = 1'b0;
      end
    end
  endfunction

  // Way to replace when the set is full.
  function automatic int model_repl_victim(int s);
    int best;
`ifdef DCACHE_PLRU_EN
    int node;
    best = 0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      best = best * 2 + int'(m_tree[s][node]);
      node = 2 * node + 1 + int'(m_tree[s][node]);
    end
`else
    best = 0;
    for (int w = 1; w < DWAYS; w++) begin
      if (m_last[s][w] < m_last[s][best]) best = w;
    end
`endif
    return best;
  endfunction

  function automatic void model_touch(int s, int w);
`ifdef DCACHE_PLRU_EN
    int node;
    int b;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = (w >> (WAY_W - 1 - l)) & 1;
      m_tree[s][node] = (b == 0);
      node = 2 * node + 1 + b;
    end
`else
    stamp_now++;
    m_last[s][w] = stamp_now;
`endif
  endfunction

  function automatic void model_lookup();
    int s;
    int t;
    int sel;
    s = int'(addr_set(bus.blockAddr));
    t = int'(addr_tag(bus.blockAddr));
    e_match = -1;
    for (int w = 0; w < DWAYS; w++) begin
      if (m_valid[s][w] && int'(m_tag[s][w]) == t) e_match = w;
    end
    e_victim = -1;
    for (int w = 0; w < DWAYS; w++) begin
      if (e_victim < 0 && !m_valid[s][w]) e_victim = w;
    end
    if (e_victim < 0) e_victim = model_repl_victim(s);
    if (!rst) begin
      e_hit = 1'b0;
      e_dirty = 1'b0;
      e_data = '0;
      e_data_known = 1'b1;
    end else begin
      e_hit = (bus.ren || bus.wen) && e_match >= 0;
      sel = e_hit ? e_match : e_victim;
      e_dirty = m_dirty[s][sel];
      e_data = m_data[s][sel];
      e_data_known = m_known[s][sel];
    end
  endfunction

  function automatic void model_commit();
    int s;
    int w;
    s = int'(addr_set(bus.blockAddr));
    if (!rst) begin
      model_reset();
    end else if (bus.memWen) begin
      w = (e_match >= 0) ? e_match : e_victim;
      m_tag[s][w]   = addr_tag(bus.blockAddr);
      m_data[s][w]  = bus.dataIn;
      m_known[s][w] = 1'b1;
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
      model_touch(s, w);
    end else if (bus.wen && e_match >= 0) begin
      for (int i = 0; i < DBLOCK_SIZE; i++) begin
        if (bus.bytesAccess[i]) m_data[s][e_match][i*8 +: 8] = bus.dataIn[i*8 +: 8];
      end
      m_dirty[s][e_match] = 1'b1;
      model_touch(s, e_match);
    end else if (bus.ren && e_match >= 0) begin
      model_touch(s, e_match);
    end
  endfunction

  task automatic drive(bit r, bit w, bit m, bmask_t be, addr_t a, line_t d);
    @(negedge clk);
    bus.ren = r;
    bus.wen = w;
    bus.memWen = m;
    bus.bytesAccess = be;
    bus.blockAddr = a;
    bus.dataIn = d;
    #1;
    model_lookup();
  endtask

  task automatic step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 0, 0, '0, mk_addr(0, 0), '0);
    step();
    drive(1, 1, 0, 8'hFF, mk_addr(3, 1), {2{32'h12345678}});
    checks++;
    if (bus.hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
    checks++;
    if (bus.dirtyBit !== 1'b0) begin failures++; $display("FAIL reset_dirty got=%b exp=0", bus.dirtyBit); end
    checks++;
    if (bus.dataOut !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.dataOut); end
    step();
    rst = 1'b1;
  endtask

  task automatic test_write_miss();
    drive(0, 1, 0, 8'hF0, mk_addr(0, 0), {$urandom, $urandom});
    checks++;
    if (bus.hit !== 1'b0) begin failures++; $display("FAIL wmiss_hit got=%b exp=0", bus.hit); end
    checks++;
    if (bus.dirtyBit !== 1'b0) begin failures++; $display("FAIL wmiss_dirty got=%b exp=0", bus.dirtyBit); end
    step();
    drive(1, 0, 0, '0, mk_addr(0, 0), '0);
    checks++;
    if (bus.hit !== 1'b0) begin failures++; $display("FAIL wmiss_after got=%b exp=0", bus.hit); end
    step();
  endtask

  task automatic test_refill_write();
    drive(0, 0, 1, 8'h00, mk_addr(0, 0), {64{1'b1}});
    step();
    drive(0, 1, 0, 8'hF0, mk_addr(0, 0), {32'hAAAAAAAA, 32'h0});
    checks++;
    if (bus.hit !== 1'b1) begin failures++; $display("FAIL wr_hit got=%b exp=1", bus.hit); end
    step();
    drive(1, 0, 0, '0, mk_addr(0, 0), '0);
    checks++;
    if (bus.hit !== 1'b1) begin failures++; $display("FAIL rd_hit got=%b exp=1", bus.hit); end
    checks++;
    if (bus.dataOut !== 64'hAAAAAAAA_FFFFFFFF) begin
      failures++; $display("FAIL rd_merge got=%h exp=aaaaaaaaffffffff", bus.dataOut);
    end
    checks++;
    if (bus.dirtyBit !== 1'b1) begin failures++; $display("FAIL rd_dirty got=%b exp=1", bus.dirtyBit); end
    step();
  endtask

  task automatic test_fill_set();
    int tags [3] = '{1, 2, 4};
    foreach (tags[i]) begin
      drive(1, 0, 0, '0, mk_addr(tags[i], 0), '0);
      checks++;
      if (bus.hit !== 1'b0) begin failures++; $display("FAIL fill_miss t=%0d got=%b exp=0", tags[i], bus.hit); end
      step();
      saved[tags[i]] = {$urandom, $urandom};
      drive(0, 0, 1, 8'h0F, mk_addr(tags[i], 0), saved[tags[i]]);
      step();
    end
    foreach (tags[i]) begin
      drive(1, 0, 0, '0, mk_addr(tags[i], 0), '0);
      checks++;
      if (bus.hit !== 1'b1) begin failures++; $display("FAIL fill_hit t=%0d got=%b exp=1", tags[i], bus.hit); end
      checks++;
      if (bus.dataOut !== saved[tags[i]]) begin
        failures++; $display("FAIL fill_data t=%0d got=%h exp=%h", tags[i], bus.dataOut, saved[tags[i]]);
      end
      checks++;
      if (bus.dirtyBit !== 1'b0) begin failures++; $display("FAIL fill_dirty t=%0d got=%b exp=0", tags[i], bus.dirtyBit); end
      step();
    end
  endtask

  task automatic test_evict();
    drive(1, 0, 0, '0, mk_addr(7, 0), '0);
    checks++;
    if (bus.hit !== 1'b0) begin failures++; $display("FAIL evict_miss got=%b exp=0", bus.hit); end
    checks++;
    if (bus.dirtyBit !== 1'b1) begin failures++; $display("FAIL evict_dirty got=%b exp=1", bus.dirtyBit); end
    checks++;
    if (bus.dataOut !== 64'hAAAAAAAA_FFFFFFFF) begin
      failures++; $display("FAIL evict_data got=%h exp=aaaaaaaaffffffff", bus.dataOut);
    end
    step();
    saved[7] = {$urandom, $urandom};
    drive(0, 0, 1, '0, mk_addr(7, 0), saved[7]);
    step();
    drive(1, 0, 0, '0, mk_addr(0, 0), '0);
    checks++;
    if (bus.hit !== 1'b0) begin failures++; $display("FAIL evicted_gone got=%b exp=0", bus.hit); end
    step();
    drive(1, 0, 0, '0, mk_addr(7, 0), '0);
    checks++;
    if (bus.hit !== 1'b1 || bus.dirtyBit !== 1'b0) begin
      failures++; $display("FAIL new_line got=%b/%b exp=1/0", bus.hit, bus.dirtyBit);
    end
    step();
  endtask

  task automatic test_lru_touch();
    drive(1, 0, 0, '0, mk_addr(1, 0), '0);
    step();
    drive(1, 0, 0, '0, mk_addr(5, 0), '0);
    checks++;
    if (bus.hit !== 1'b0) begin failures++; $display("FAIL touch_miss got=%b exp=0", bus.hit); end
    checks++;
    if (bus.dataOut !== saved[2]) begin
      failures++; $display("FAIL touch_victim got=%h exp=%h", bus.dataOut, saved[2]);
    end
    step();
    drive(1, 0, 0, '0, mk_addr(1, 1), '0);
    checks++;
    if (bus.hit !== 1'b0 || bus.dirtyBit !== 1'b0) begin
      failures++; $display("FAIL set1_clean got=%b/%b exp=0/0", bus.hit, bus.dirtyBit);
    end
    step();
  endtask

  task automatic test_random();
    bit r, w, m;
    for (int n = 0; n < 400; n++) begin
      m = ($urandom_range(0, 3) == 0);
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      drive(r, w, m, bmask_t'($urandom), mk_addr($urandom_range(0, 7), $urandom_range(0, 1)),
            {$urandom, $urandom});
      checks++;
      if (bus.hit !== e_hit) begin failures++; $display("FAIL rand_hit n=%0d got=%b exp=%b", n, bus.hit, e_hit); end
      checks++;
      if (bus.dirtyBit !== e_dirty) begin
        failures++; $display("FAIL rand_dirty n=%0d got=%b exp=%b", n, bus.dirtyBit, e_dirty);
      end
      if (e_data_known) begin
        checks++;
        if (bus.dataOut !== e_data) begin
          failures++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, bus.dataOut, e_data);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    bit had [DSETS][8];
    for (int s = 0; s < DSETS; s++) begin
      for (int t = 0; t < 8; t++) had[s][t] = 1'b0;
      for (int w = 0; w < DWAYS; w++) if (m_valid[s][w]) had[s][int'(m_tag[s][w])] = 1'b1;
    end
    rst = 1'b0;
    drive(1, 0, 0, '0, mk_addr(7, 0), '0);
    checks++;
    if (bus.hit !== 1'b0 || bus.dirtyBit !== 1'b0 || bus.dataOut !== 64'h0) begin
      failures++; $display("FAIL midrst_out got=%b/%b/%h exp=0/0/0", bus.hit, bus.dirtyBit, bus.dataOut);
    end
    step();
    rst = 1'b1;
    for (int s = 0; s < DSETS; s++) begin
      for (int t = 0; t < 8; t++) begin
        if (had[s][t]) begin
          drive(1, 1, 0, 8'h00, mk_addr(t, s), '0);
          checks++;
          if (bus.hit !== 1'b0 || bus.dirtyBit !== 1'b0) begin
            failures++; $display("FAIL midrst_miss s=%0d t=%0d got=%b/%b exp=0/0", s, t, bus.hit, bus.dirtyBit);
          end
          step();
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    stamp_now = 0;
    for (int s = 0; s < DSETS; s++) for (int w = 0; w < DWAYS; w++) m_known[s][w] = 1'b0;
    model_reset();
    rst = 1'b0;
    bus.ren = 1'b0;
    bus.wen = 1'b0;
    bus.memWen = 1'b0;
    bus.bytesAccess = '0;
    bus.blockAddr = '0;
    bus.dataIn = '0;
    test_reset();
    test_write_miss();
    test_refill_write();
    test_fill_set();
    test_evict();
    test_lru_touch();
    test_random();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
